wb_msp_frame_tx: RTL

Wishbone-programmed MSP v1 response-frame transmitter: firmware loads a payload buffer plus command/size, strobes start, and the block serialises a complete `$M>` (or `$M!` error) frame with XOR checksum onto the PC-side UART transmit byte stream. It is the reply direction of the PC-link MSP traffic whose requests (`$M<`) are sniffed by the serial/DSHOT mux. It sits on the same Wishbone bus and drives the 115200 PC UART transmitter's parallel byte port.

---
 rtl/msp_pkg.sv | 26 ++
 rtl/msp_tx_fsm.sv | 120 ++++++++++++
 rtl/wb_msp_frame_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/msp_pkg.sv
// Shared definitions for the MSP v1 response-frame transmitter: framing states,
// MSP header/direction bytes and the Wishbone register map.
package msp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOLLAR,
    ST_MCHR,
    ST_DIR,
    ST_SIZE,
    ST_CMD,
    ST_PAYLOAD,
    ST_CSUM
  } msp_tx_state_e;

  localparam logic [7:0] MSP_HDR_DOLLAR = 8'h24;
  localparam logic [7:0] MSP_HDR_M      = 8'h4D;
  localparam logic [7:0] MSP_DIR_REQ    = 8'h3C;
  localparam logic [7:0] MSP_DIR_RESP   = 8'h3E;
  localparam logic [7:0] MSP_DIR_ERR    = 8'h21;

  localparam logic [31:0] MSP_REG_CTRL   = 32'h0000_0500;
  localparam logic [31:0] MSP_REG_STATUS = 32'h0000_0504;
  localparam logic [31:0] MSP_BUF_BASE   = 32'h0000_0600;

endpackage

// File: rtl/msp_tx_fsm.sv
// Framing engine: walks the $M> / $M! frame one byte per accepted handshake,
// folding size, cmd and payload into the XOR checksum as they leave.
//
// state      | meaning
// -----------+-------------------------------------------
// ST_IDLE    | no frame, tx_valid_o low
// ST_DOLLAR  | driving '$'
// ST_MCHR    | driving 'M'
// ST_DIR     | driving '>' (or '!' for an error reply)
// ST_SIZE    | driving payload size
// ST_CMD     | driving command id
// ST_PAYLOAD | driving payload byte pay_idx
// ST_CSUM    | driving XOR checksum, frame ends on accept
module msp_tx_fsm
  import msp_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start,
  input  logic       err_dir,
  input  logic [7:0] cmd,
  input  logic [7:0] size,
  input  logic [7:0] pay_byte,
  output logic [5:0] pay_idx,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_busy_o,
  output logic       frame_done
);

  msp_tx_state_e state, state_nxt;
  logic [5:0]    idx, idx_nxt;
  logic [7:0]    csum, csum_nxt;
  logic [7:0]    byte_nxt;
  logic          accept;

  assign accept  = tx_valid_o & tx_ready_i;
  assign pay_idx = idx_nxt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      csum       <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      tx_busy_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      csum       <= csum_nxt;
      tx_data_o  <= byte_nxt;
      tx_valid_o <= (state_nxt != ST_IDLE);
      tx_busy_o  <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    csum_nxt   = csum;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_DOLLAR;
          csum_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      ST_DOLLAR: if (accept) state_nxt = ST_MCHR;
      ST_MCHR:   if (accept) state_nxt = ST_DIR;
      ST_DIR:    if (accept) state_nxt = ST_SIZE;
      ST_SIZE: begin
        if (accept) begin
          csum_nxt  = csum ^ tx_data_o;
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (accept) begin
          csum_nxt  = csum ^ tx_data_o;
          idx_nxt   = '0;
          state_nxt = (size == 8'd0) ? ST_CSUM : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          csum_nxt = csum ^ tx_data_o;
          if ({2'b00, idx} == size - 8'd1) state_nxt = ST_CSUM;
          else                             idx_nxt   = idx + 6'd1;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_nxt  = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output byte is chosen for the state being entered so tx_data_o stays registered.
  always_comb begin
    byte_nxt = 8'h00;
    case (state_nxt)
      ST_DOLLAR:  byte_nxt = MSP_HDR_DOLLAR;
      ST_MCHR:    byte_nxt = MSP_HDR_M;
      ST_DIR:     byte_nxt = err_dir ? MSP_DIR_ERR : MSP_DIR_RESP;
      ST_SIZE:    byte_nxt = size;
      ST_CMD:     byte_nxt = cmd;
      ST_PAYLOAD: byte_nxt = pay_byte;
      ST_CSUM:    byte_nxt = csum_nxt;
      default:    byte_nxt = 8'h00;
    endcase
  end

endmodule

// File: rtl/wb_msp_frame_tx.sv
// Wishbone-programmed MSP v1 reply transmitter: CTRL/STATUS registers, payload
// buffer and the framing FSM. Optional frame-done interrupt via MSP_TX_IRQ_EN.
module wb_msp_frame_tx
  import msp_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_busy_o
`ifdef MSP_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam logic [7:0]  MAX_SIZE = 8'(MAX_PAYLOAD);
  localparam logic [31:0] BUF_LEN  = 32'(MAX_PAYLOAD);

  logic [7:0]  buf_mem [MAX_PAYLOAD];
  logic [7:0]  cmd_q, size_q;
  logic        err_dir_q, done_q, size_err_q;
  logic        irq_en_q;

  logic        sel, acc, wr, rd;
  logic [31:0] word_adr, buf_off, rd_data;
  logic        hit_ctrl, hit_stat, hit_buf;
  logic        start_req, size_ok, fsm_start, frame_done;
  logic [5:0]  pay_idx;
  logic [3:0]  buf_word;

  assign wb_stall_o = 1'b0;

  assign sel      = wb_stb_i & wb_cyc_i;
  assign acc      = sel & ~wb_ack_o;
  assign wr       = acc & wb_we_i;
  assign rd       = acc & ~wb_we_i;
  assign word_adr = {wb_adr_i[31:2], 2'b00};
  assign hit_ctrl = (word_adr == MSP_REG_CTRL);
  assign hit_stat = (word_adr == MSP_REG_STATUS);
  // Addresses below the base wrap to a large offset, so one compare bounds both ends.
  assign buf_off  = word_adr - MSP_BUF_BASE;
  assign hit_buf  = (buf_off < BUF_LEN);
  assign buf_word = buf_off[5:2];

  assign start_req = wr & hit_ctrl & wb_dat_i[0] & ~tx_busy_o;
  assign size_ok   = (wb_dat_i[23:16] <= MAX_SIZE);
  assign fsm_start = start_req & size_ok;

`ifdef MSP_TX_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr & hit_ctrl & ~tx_busy_o) irq_en_q <= wb_dat_i[2];
      irq_o <= frame_done & irq_en_q;
    end
  end
`else
  assign irq_en_q = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      cmd_q      <= '0;
      size_q     <= '0;
      err_dir_q  <= 1'b0;
      done_q     <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= rd ? rd_data : 32'h0;
      if (wr & hit_ctrl & ~tx_busy_o) begin
        err_dir_q <= wb_dat_i[1];
        cmd_q     <= wb_dat_i[15:8];
        size_q    <= wb_dat_i[23:16];
      end
      if (start_req & ~size_ok)                size_err_q <= 1'b1;
      else if (wr & hit_stat & wb_dat_i[2])    size_err_q <= 1'b0;
      if (frame_done)                          done_q     <= 1'b1;
      else if (wr & hit_stat & wb_dat_i[1])    done_q     <= 1'b0;
    end
  end

  // Payload buffer keeps its contents across reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr & hit_buf & ~tx_busy_o) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) buf_mem[{buf_word, 2'(b)}] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (hit_ctrl)
      rd_data = {8'h00, size_q, cmd_q, 5'b0, irq_en_q, err_dir_q, 1'b0};
    else if (hit_stat)
      rd_data = {29'b0, size_err_q, done_q, tx_busy_o};
    else if (hit_buf)
      rd_data = {buf_mem[{buf_word, 2'd3}], buf_mem[{buf_word, 2'd2}],
                 buf_mem[{buf_word, 2'd1}], buf_mem[{buf_word, 2'd0}]};
  end

  msp_tx_fsm u_fsm (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start      (fsm_start),
    .err_dir    (err_dir_q),
    .cmd        (cmd_q),
    .size       (size_q),
    .pay_byte   (buf_mem[pay_idx]),
    .pay_idx    (pay_idx),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_busy_o  (tx_busy_o),
    .frame_done (frame_done)
  );

endmodule
